// File: rtl/idli_pkg.sv
// idli_pkg: shared types for the idli core.
//   ctr_t        2-bit slice counter shared by EX and its peripherals
//   slice_t      4-bit datapath slice
//   URX_WORD_W   width of a received UART word
//   urx_state_t  UART receiver FSM states; URX_PARITY exists only when
//                IDLI_URX_PARITY_EN is defined
package idli_pkg;

  typedef logic [1:0] ctr_t;
  typedef logic [3:0] slice_t;

  localparam int URX_WORD_W = 16;

  typedef enum logic [2:0] {
    URX_IDLE,
    URX_START,
    URX_DATA,
`ifdef IDLI_URX_PARITY_EN
    URX_PARITY,
`endif
    URX_STOP
  } urx_state_t;

endpackage

// File: rtl/idli_urx_fifo_m.sv
// idli_urx_fifo_m: DEPTH-entry FIFO of received UART words.
//   i_fifo_gck     core clock
//   i_fifo_rst_n   async active-low reset (pointers and count only)
//   i_fifo_push    write i_fifo_wdata; accepted when not full, or when full
//                  and a pop happens in the same cycle
//   i_fifo_pop     drop the head entry (ignored when empty)
//   o_fifo_head    head entry, valid while !o_fifo_empty
//   o_fifo_full / o_fifo_empty / o_fifo_lvl   occupancy status
module idli_urx_fifo_m
  import idli_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         i_fifo_gck,
  input  logic                         i_fifo_rst_n,
  input  logic                         i_fifo_push,
  input  logic [URX_WORD_W-1:0]        i_fifo_wdata,
  input  logic                         i_fifo_pop,
  output logic [URX_WORD_W-1:0]        o_fifo_head,
  output logic                         o_fifo_full,
  output logic                         o_fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_fifo_lvl
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [URX_WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      cnt_q;
  logic                  push_ok, pop_ok;

  assign o_fifo_full  = (cnt_q == LVL_W'(DEPTH));
  assign o_fifo_empty = (cnt_q == '0);
  assign o_fifo_lvl   = cnt_q;
  assign o_fifo_head  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the write lands in
  // (wr_ptr == rd_ptr), so the push can be taken.
  assign pop_ok  = i_fifo_pop && !o_fifo_empty;
  assign push_ok = i_fifo_push && (!o_fifo_full || pop_ok);

  always_ff @(posedge i_fifo_gck) begin
    if (push_ok) mem_q[wr_ptr_q] <= i_fifo_wdata;
  end

  always_ff @(posedge i_fifo_gck or negedge i_fifo_rst_n) begin
    if (!i_fifo_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/idli_urxq_m.sv
// idli_urxq_m: buffered UART receiver feeding EX through a word FIFO.
// Frame: start(0), 16 data bits LSB first, [even parity], stop(1).
// Build option: define IDLI_URX_PARITY_EN to expect an even-parity bit.
//   i_urx_gck / i_urx_rst_n   core clock, async active-low reset
//   i_urx_data                serial line (idles high), already synchronous
//   i_urx_ctr                 slice counter shared with EX
//   o_urx_data                head-word slice for i_urx_ctr, 0 when empty
//   o_urx_vld / o_urx_lvl     FIFO non-empty / occupancy
//   i_urx_acp                 EX consuming the head; pops at ctr==3
//   o_urx_ovf / o_urx_ferr    sticky overflow / framing(parity) flags
//   i_urx_clr                 clears both flags (a same-cycle set wins)
module idli_urxq_m
  import idli_pkg::*;
#(
  parameter int BIT_CYC = 1,
  parameter int DEPTH   = 4
) (
  input  logic                        i_urx_gck,
  input  logic                        i_urx_rst_n,
  input  ctr_t                        i_urx_ctr,
  output slice_t                      o_urx_data,
  output logic                        o_urx_vld,
  input  logic                        i_urx_acp,
  output logic [$clog2(DEPTH+1)-1:0]  o_urx_lvl,
  output logic                        o_urx_ovf,
  output logic                        o_urx_ferr,
  input  logic                        i_urx_clr,
  input  logic                        i_urx_data
);

  localparam int TMR_W = $clog2(BIT_CYC+1);
  localparam logic [TMR_W-1:0] FULL_LD = TMR_W'(BIT_CYC-1);
  localparam logic [TMR_W-1:0] HALF_LD = TMR_W'((BIT_CYC/2 > 0) ? BIT_CYC/2 - 1 : 0);
  // With one cycle per bit the mid-point of the start bit is the detect
  // cycle itself, so the start re-check is skipped.
  localparam bit SKIP_START = (BIT_CYC < 2);

  urx_state_t            state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [URX_WORD_W-1:0] shift_q, shift_d;
  logic                  ovf_q, ovf_d, ferr_q, ferr_d;
  logic                  push, frm_err, pop, full, empty, tick, par_ok;
  logic [URX_WORD_W-1:0] head;

`ifdef IDLI_URX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_ok = !par_err_q;
`else
  assign par_ok = 1'b1;
`endif

  assign tick = (tmr_q == '0);

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frm_err   = 1'b0;
`ifdef IDLI_URX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      URX_IDLE: begin
        if (!i_urx_data) begin
          if (SKIP_START) begin
            state_d = URX_DATA;
            tmr_d   = FULL_LD;
          end else begin
            state_d = URX_START;
            tmr_d   = HALF_LD;
          end
        end
      end
      URX_START: begin
        if (tick) begin
          if (i_urx_data) begin
            state_d   = URX_IDLE;
            tmr_d     = '0;
            bit_cnt_d = '0;
          end else begin
            state_d = URX_DATA;
            tmr_d   = FULL_LD;
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      URX_DATA: begin
        if (tick) begin
          shift_d   = {i_urx_data, shift_q[URX_WORD_W-1:1]};
          tmr_d     = FULL_LD;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd15) begin
`ifdef IDLI_URX_PARITY_EN
            state_d = URX_PARITY;
`else
            state_d = URX_STOP;
`endif
          end
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
`ifdef IDLI_URX_PARITY_EN
      URX_PARITY: begin
        if (tick) begin
          // Even parity: data ones plus the parity bit must be even.
          par_err_d = i_urx_data ^ (^shift_q);
          state_d   = URX_STOP;
          tmr_d     = FULL_LD;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
`endif
      URX_STOP: begin
        if (tick) begin
          state_d   = URX_IDLE;
          tmr_d     = '0;
          bit_cnt_d = '0;
          if (i_urx_data && par_ok) push    = 1'b1;
          else                      frm_err = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: begin
        state_d   = URX_IDLE;
        tmr_d     = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign pop    = o_urx_vld && i_urx_acp && (i_urx_ctr == 2'd3);
  assign ovf_d  = (ovf_q  && !i_urx_clr) || (push && full && !pop);
  assign ferr_d = (ferr_q && !i_urx_clr) || frm_err;

  always_ff @(posedge i_urx_gck or negedge i_urx_rst_n) begin
    if (!i_urx_rst_n) begin
      state_q   <= URX_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef IDLI_URX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
`ifdef IDLI_URX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  idli_urx_fifo_m #(.DEPTH(DEPTH)) u_fifo (
    .i_fifo_gck   (i_urx_gck),
    .i_fifo_rst_n (i_urx_rst_n),
    .i_fifo_push  (push),
    .i_fifo_wdata (shift_q),
    .i_fifo_pop   (pop),
    .o_fifo_head  (head),
    .o_fifo_full  (full),
    .o_fifo_empty (empty),
    .o_fifo_lvl   (o_urx_lvl)
  );

  assign o_urx_vld  = !empty;
  assign o_urx_data = o_urx_vld ? head[4*i_urx_ctr +: 4] : '0;
  assign o_urx_ovf  = ovf_q;
  assign o_urx_ferr = ferr_q;

endmodule
